// File: rtl/countdown_timer_pkg.sv
// Shared constants for the interval timer: state encoding and default widths
// matching the CPU word.
package countdown_timer_pkg;

  localparam int CPU_WORD_W       = 20;
  localparam int TIMER_PRESCALE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/countdown_timer_dec_unit.sv
// Combinational WIDTH-bit decrement with borrow out; borrow is set only when
// the input is zero, i.e. the result wrapped to all-ones.
module dec_unit #(
  parameter int WIDTH = 20
) (
  input  logic [WIDTH-1:0] value_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
);

  // The extra top bit of the widened subtraction is the borrow.
  assign {borrow_o, diff_o} = {1'b0, value_i} - {{WIDTH{1'b0}}, 1'b1};

endmodule

// File: rtl/countdown_timer.sv
// Prescaled down-counter timer with load/start/stop strobes, one-shot or
// auto-reload operation and a one-cycle expiry pulse.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH      = CPU_WORD_W,
  parameter int PRESCALE_W = TIMER_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  auto_reload,
  output logic [WIDTH-1:0]      count,
  output logic                  running,
  output logic                  done,
  output logic                  expired
);

  state_e                state_q;
  logic [WIDTH-1:0]      count_q;
  logic [WIDTH-1:0]      reload_q;
  logic [PRESCALE_W-1:0] p_q;
  logic [PRESCALE_W-1:0] pre_q;
  logic                  running_q;
  logic                  done_q;
  logic                  expired_q;

  logic [WIDTH-1:0]      dec_value;
  logic                  dec_borrow;

  dec_unit #(.WIDTH(WIDTH)) u_dec (
    .value_i  (count_q),
    .diff_o   (dec_value),
    .borrow_o (dec_borrow)
  );

  // Priority per edge: rst > load > stop > start > prescaler tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      p_q       <= '0;
      pre_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      expired_q <= 1'b0;
      if (load) begin
        // State is untouched, so a load while running restarts the period.
        count_q  <= load_value;
        reload_q <= load_value;
        pre_q    <= '0;
      end else if (stop) begin
        state_q   <= ST_IDLE;
        running_q <= 1'b0;
        done_q    <= 1'b0;
        pre_q     <= '0;
      end else if (start && (state_q != ST_RUN)) begin
        state_q   <= ST_RUN;
        running_q <= 1'b1;
        done_q    <= 1'b0;
        p_q       <= prescale;
        pre_q     <= '0;
      end else if (state_q == ST_RUN) begin
        if (pre_q == p_q) begin
          pre_q <= '0;
          if (!dec_borrow) begin
            count_q <= dec_value;
          end else begin
            // Borrow out of zero is the expiry; the wrapped value is never kept.
            expired_q <= 1'b1;
            if (auto_reload) begin
              count_q <= reload_q;
            end else begin
              state_q   <= ST_DONE;
              running_q <= 1'b0;
              done_q    <= 1'b1;
            end
          end
        end else begin
          pre_q <= pre_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign count   = count_q;
  assign running = running_q;
  assign done    = done_q;
  assign expired = expired_q;

endmodule
